axis_round_robin_demux: RTL and testbench
=========================================

Name: axis_round_robin_demux

Overview:
- Packet-level 1-to-CHANNEL_NUM AXI4-Stream distributor; the transmit-side counterpart of the round-robin mux.
- Each whole packet from one slave stream goes to one enabled master channel, chosen in round-robin order.
- Exports the current grant as one-hot sel_o, which can drive the select of the matching mux.
- One registered output stage.

Parameters:
DATA_WIDTH, 32, tdata width per channel in bits; multiple of 8.
CHANNEL_NUM, 8, number of master channels; 2..32.
TKEEP_WIDTH (localparam), DATA_WIDTH/8, tkeep width per channel.
CNT_WIDTH, 16, width of each per-channel packet counter (optional feature only).

Ports:
clk_i  in  1  clock; all logic on rising edge.
arstn_i  in  1  asynchronous active-low reset.
en_i  in  CHANNEL_NUM  per-channel enable mask; channels at 0 are skipped.
sel_o  out  CHANNEL_NUM  one-hot current grant; 0 when idle.
s_axis_tvalid  in  1  slave valid.
s_axis_tready  out  1  slave ready.
s_axis_tdata  in  DATA_WIDTH  slave data.
s_axis_tkeep  in  TKEEP_WIDTH  slave byte enables.
s_axis_tlast  in  1  slave end of packet.
m_axis_tvalid  out  CHANNEL_NUM  per-channel valid; at most one bit set.
m_axis_tready  in  CHANNEL_NUM  per-channel ready.
m_axis_tdata  out  CHANNEL_NUM*DATA_WIDTH  flattened; same registered data broadcast to every slice.
m_axis_tkeep  out  CHANNEL_NUM*TKEEP_WIDTH  flattened; same data broadcast to every slice.
m_axis_tlast  out  CHANNEL_NUM  per-channel last; same value broadcast to every bit.
pkt_cnt_o  out  CHANNEL_NUM*CNT_WIDTH  per-channel packet counts; present only with AXIS_RR_DEMUX_PKT_CNT_EN.

Behaviour:
- Reset: asynchronous assert, synchronous release.
  - state=IDLE, ptr=0, sel_o=0, s_axis_tready=0, m_axis_tvalid=0.
  - Output register cleared: valid_q=0, dst_q=0, data/keep/last=0. Any in-flight beat is dropped.
- Output register holds valid_q, dst_q (channel index), data, keep, last.
  - m_axis_tvalid[dst_q]=valid_q; all other tvalid bits are 0.
  - pop = valid_q && m_axis_tready[dst_q].
- FSM, two states:
  - IDLE: s_axis_tready=0 and sel_o=0.
    - If en_i!=0: grant = first enabled index searching ptr, ptr+1, ... with wrap mod CHANNEL_NUM. Go to ACTIVE; sel_o=onehot(grant) from the next cycle.
    - If en_i==0: stay in IDLE.
  - ACTIVE: s_axis_tready = !valid_q || pop (combinational from registered state and m_axis_tready).
    - Accepted beat loads the register with dst_q=grant in the same edge as any pop.
    - Accepted beat with tlast=1: ptr <= (grant+1) mod CHANNEL_NUM; go to IDLE.
- Throughput: 1 beat/cycle within a packet; exactly 1 bubble cycle (IDLE) between packets.
- Latency: accepted beat appears on m_axis 1 cycle later.
- Register may still drain the previous packet's last beat while the new grant is active. Ordering holds because only one beat is ever stored.
- en_i changes are sampled only in IDLE. Deasserting the granted channel mid-packet does not abort the packet; it completes to that channel.
- Single-beat packet (tlast on first beat) is legal; FSM goes ACTIVE→IDLE after one beat.
- Only one channel enabled: every packet goes to it.
- No backpressure ever drops data. m_axis outputs hold stable while tvalid=1 and tready=0.
- tkeep/tdata/tlast are passed through unmodified; no checks performed.

Optional Feature:
- Macro AXIS_RR_DEMUX_PKT_CNT_EN.
- Defined:
  - pkt_cnt_o exists. Channel i's CNT_WIDTH counter increments by 1 on each pop with last=1 and dst_q=i.
  - Counters wrap modulo 2^CNT_WIDTH; reset to 0.
- Undefined: port and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, en_i=8'hFF, three 4-beat packets, all m_axis_tready=1 → packets on channels 0, 1, 2; each beat 1 cycle after accept; one s_axis_tready=0 cycle between packets; sel_o=01,02,04.
- en_i=8'b1010_0100, five 1-beat packets → destinations 2, 5, 7, 2, 5.
- Packet to ch0, m_axis_tready[0]=0 for 5 cycles mid-packet → s_axis_tready low; tdata held stable; no beat lost or duplicated.
- en_i=0 with s_axis_tvalid=1 for 10 cycles → s_axis_tready=0, sel_o=0, no m_axis_tvalid; set en_i[3]=1 → packet on ch3.
- Assert arstn_i during the 3rd beat of a packet → all m_axis_tvalid=0 immediately; after release, next packet goes to ch0.
- With AXIS_RR_DEMUX_PKT_CNT_EN, CNT_WIDTH=2, five packets with only ch1 enabled → pkt_cnt_o ch1 slice=1 (wrapped); other slices 0.

Source files
------------

// File: rtl/axis_round_robin_demux.sv
// Packet-level 1-to-CHANNEL_NUM AXI4-Stream round-robin distributor with one registered output stage.
// Optional per-channel packet counters are enabled by defining AXIS_RR_DEMUX_PKT_CNT_EN.
module axis_round_robin_demux #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned CHANNEL_NUM = 8,
   parameter int unsigned CNT_WIDTH   = 16,
   localparam int unsigned TKEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic                               clk_i,
   input  logic                               arstn_i,
   input  logic [CHANNEL_NUM-1:0]             en_i,
   output logic [CHANNEL_NUM-1:0]             sel_o,
   input  logic                               s_axis_tvalid,
   output logic                               s_axis_tready,
   input  logic [DATA_WIDTH-1:0]              s_axis_tdata,
   input  logic [TKEEP_WIDTH-1:0]             s_axis_tkeep,
   input  logic                               s_axis_tlast,
   output logic [CHANNEL_NUM-1:0]             m_axis_tvalid,
   input  logic [CHANNEL_NUM-1:0]             m_axis_tready,
   output logic [CHANNEL_NUM*DATA_WIDTH-1:0]  m_axis_tdata,
   output logic [CHANNEL_NUM*TKEEP_WIDTH-1:0] m_axis_tkeep,
   output logic [CHANNEL_NUM-1:0]             m_axis_tlast
`ifdef AXIS_RR_DEMUX_PKT_CNT_EN
   ,
   output logic [CHANNEL_NUM*CNT_WIDTH-1:0]   pkt_cnt_o
`endif
);

   localparam int unsigned PTR_W = $clog2(CHANNEL_NUM);

   if (DATA_WIDTH % 8 != 0 || CHANNEL_NUM < 2 || CHANNEL_NUM > 32 || CNT_WIDTH < 1)
   begin : g_param_check
      $error("axis_round_robin_demux: invalid parameter set");
   end

   typedef enum logic {StIdle, StActive} state_t;

   state_t                   state_q, state_d;
   logic [PTR_W-1:0]         ptr_q, ptr_d;
   logic [PTR_W-1:0]         grant_q, grant_d;
   logic [PTR_W-1:0]         pick;
   logic [PTR_W-1:0]         grant_inc;
   logic                     found;
   logic                     valid_q;
   logic [PTR_W-1:0]         dst_q;
   logic [DATA_WIDTH-1:0]    data_q;
   logic [TKEEP_WIDTH-1:0]   keep_q;
   logic                     last_q;
   logic                     pop;
   logic                     accept;

   // First enabled channel at or after ptr_q, wrapping around.
   always_comb begin
      pick  = ptr_q;
      found = 1'b0;
      for (int k = 0; k < int'(CHANNEL_NUM); k++) begin
         if (!found && en_i[(int'(ptr_q) + k) % int'(CHANNEL_NUM)]) begin
            found = 1'b1;
            pick  = PTR_W'((int'(ptr_q) + k) % int'(CHANNEL_NUM));
         end
      end
   end

   assign grant_inc = (grant_q == PTR_W'(CHANNEL_NUM - 1)) ? '0 : grant_q + 1'b1;
   assign pop       = valid_q && m_axis_tready[dst_q];
   assign accept    = (state_q == StActive) && s_axis_tvalid && s_axis_tready;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      grant_d       = grant_q;
      s_axis_tready = 1'b0;
      sel_o         = '0;
      unique case (state_q)
         StIdle: begin
            if (|en_i) begin
               state_d = StActive;
               grant_d = pick;
            end
         end
         StActive: begin
            // The single-entry output stage can take a beat whenever it empties this cycle.
            s_axis_tready  = !valid_q || pop;
            sel_o[grant_q] = 1'b1;
            if (s_axis_tvalid && s_axis_tready && s_axis_tlast) begin
               state_d = StIdle;
               ptr_d   = grant_inc;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         valid_q <= 1'b0;
         dst_q   <= '0;
         data_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
      end else if (accept) begin
         valid_q <= 1'b1;
         dst_q   <= grant_q;
         data_q  <= s_axis_tdata;
         keep_q  <= s_axis_tkeep;
         last_q  <= s_axis_tlast;
      end else if (pop) begin
         valid_q <= 1'b0;
      end
   end

   always_comb begin
      m_axis_tvalid        = '0;
      m_axis_tvalid[dst_q] = valid_q;
   end

   assign m_axis_tdata = {CHANNEL_NUM{data_q}};
   assign m_axis_tkeep = {CHANNEL_NUM{keep_q}};
   assign m_axis_tlast = {CHANNEL_NUM{last_q}};

`ifdef AXIS_RR_DEMUX_PKT_CNT_EN
   logic [CHANNEL_NUM*CNT_WIDTH-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         cnt_q <= '0;
      end else begin
         for (int i = 0; i < int'(CHANNEL_NUM); i++) begin
            if (pop && last_q && (dst_q == PTR_W'(i))) begin
               cnt_q[i*CNT_WIDTH +: CNT_WIDTH] <= cnt_q[i*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
            end
         end
      end
   end

   assign pkt_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_axis_round_robin_demux.sv
// Directed bench for axis_round_robin_demux: queue-based packet model checked every cycle,
// plus hand-computed destination and stall expectations.
module tb_axis_round_robin_demux;

   localparam int unsigned DW = 32;
   localparam int unsigned KW = DW / 8;
   localparam int unsigned N  = 8;
   localparam int unsigned CW = 2;

   logic              clk = 1'b0;
   logic              arstn = 1'b0;
   logic [N-1:0]      en_i = '0;
   logic [N-1:0]      sel_o;
   logic              s_axis_tvalid = 1'b0;
   logic              s_axis_tready;
   logic [DW-1:0]     s_axis_tdata = '0;
   logic [KW-1:0]     s_axis_tkeep = '0;
   logic              s_axis_tlast = 1'b0;
   logic [N-1:0]      m_axis_tvalid;
   logic [N-1:0]      m_axis_tready = '1;
   logic [N*DW-1:0]   m_axis_tdata;
   logic [N*KW-1:0]   m_axis_tkeep;
   logic [N-1:0]      m_axis_tlast;
`ifdef AXIS_RR_DEMUX_PKT_CNT_EN
   logic [N*CW-1:0]   pkt_cnt_o;
`endif

   always #5 clk = ~clk;

   axis_round_robin_demux #(
      .DATA_WIDTH  (DW),
      .CHANNEL_NUM (N),
      .CNT_WIDTH   (CW)
   ) dut (
      .clk_i         (clk),
      .arstn_i       (arstn),
      .en_i          (en_i),
      .sel_o         (sel_o),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast)
`ifdef AXIS_RR_DEMUX_PKT_CNT_EN
      ,
      .pkt_cnt_o     (pkt_cnt_o)
`endif
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a granted destination, a round-robin start pointer and the beats held at the output.
   typedef struct {
      int            dst;
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;

   beat_t        held[$];
   int           dlog[$];
   int           mcnt[N];
   bit           mdl_busy = 0;
   int           mdl_dst  = 0;
   int           mdl_ptr  = 0;
   int           d;
   logic [N-1:0] exp_tv;
   logic [N-1:0] exp_sel;
   logic         exp_tready;
   beat_t        nb;

   function automatic int rr_pick(input logic [N-1:0] en, input int ptr);
      for (int k = 0; k < int'(N); k++) begin
         if (en[(ptr + k) % int'(N)]) return (ptr + k) % int'(N);
      end
      return ptr;
   endfunction

   always @(negedge clk) begin
      if (!arstn) begin
         check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
         check("rst_sel", 64'(sel_o), 64'd0);
         check("rst_tready", 64'(s_axis_tready), 64'd0);
         held.delete();
         mdl_busy = 0;
         mdl_ptr  = 0;
         mdl_dst  = 0;
         for (int i = 0; i < int'(N); i++) mcnt[i] = 0;
      end else begin
         exp_tv = '0;
         if (held.size() > 0) exp_tv[held[0].dst] = 1'b1;
         exp_sel = '0;
         if (mdl_busy) exp_sel[mdl_dst] = 1'b1;
         exp_tready = mdl_busy && (held.size() == 0 || m_axis_tready[held[0].dst]);
         check("tvalid", 64'(m_axis_tvalid), 64'(exp_tv));
         check("sel", 64'(sel_o), 64'(exp_sel));
         check("s_tready", 64'(s_axis_tready), 64'(exp_tready));
         if (held.size() > 0) begin
            d = held[0].dst;
            check("tdata", 64'(m_axis_tdata[d*DW +: DW]), 64'(held[0].data));
            check("tkeep", 64'(m_axis_tkeep[d*KW +: KW]), 64'(held[0].keep));
            check("tlast", 64'(m_axis_tlast[d]), 64'(held[0].last));
            if (m_axis_tready[d]) begin
               if (held[0].last) begin
                  dlog.push_back(d);
                  mcnt[d] = (mcnt[d] + 1) % (1 << CW);
               end
               void'(held.pop_front());
            end
         end
         if (mdl_busy) begin
            if (s_axis_tvalid && exp_tready) begin
               nb.dst  = mdl_dst;
               nb.data = s_axis_tdata;
               nb.keep = s_axis_tkeep;
               nb.last = s_axis_tlast;
               held.push_back(nb);
               if (s_axis_tlast) begin
                  mdl_busy = 0;
                  mdl_ptr  = (mdl_dst + 1) % int'(N);
               end
            end
         end else if (en_i != '0) begin
            mdl_dst  = rr_pick(en_i, mdl_ptr);
            mdl_busy = 1;
         end
      end
   end

   task automatic reset_dut(input logic [N-1:0] en);
      arstn         = 1'b0;
      s_axis_tvalid = 1'b0;
      m_axis_tready = '1;
      en_i          = en;
      repeat (2) @(posedge clk);
      #1 arstn = 1'b1;
   endtask

   task automatic send_beat(input logic [DW-1:0] data, input logic [KW-1:0] keep, input logic last);
      bit ok = 0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = data;
      s_axis_tkeep  = keep;
      s_axis_tlast  = last;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (s_axis_tready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("accept_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic send_pkt(input int len, input logic [DW-1:0] base);
      for (int b = 0; b < len; b++) begin
         send_beat(base + DW'(b), KW'(b + 1), (b == len - 1));
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic drain;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_dest(input string name, input int start, input int idx, input int exp);
      if (dlog.size() > start + idx) check(name, 64'(dlog[start + idx]), 64'(exp));
      else check({name, "_missing"}, 64'(dlog.size()), 64'(start + idx + 1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int start;

      // Three 4-beat packets, all channels enabled.
      reset_dut('1);
      start = dlog.size();
      for (int p = 0; p < 3; p++) send_pkt(4, 32'h100 + 32'(p) * 32'h10);
      drain();
      check_dest("t1_dst0", start, 0, 0);
      check_dest("t1_dst1", start, 1, 1);
      check_dest("t1_dst2", start, 2, 2);

      // Sparse enable mask, single-beat packets.
      reset_dut(8'b1010_0100);
      start = dlog.size();
      for (int p = 0; p < 5; p++) send_pkt(1, 32'h200 + 32'(p));
      drain();
      check_dest("t2_dst0", start, 0, 2);
      check_dest("t2_dst1", start, 1, 5);
      check_dest("t2_dst2", start, 2, 7);
      check_dest("t2_dst3", start, 3, 2);
      check_dest("t2_dst4", start, 4, 5);

      // Backpressure on ch0 mid-packet.
      reset_dut('1);
      start = dlog.size();
      fork
         send_pkt(6, 32'h300);
         begin
            repeat (3) @(posedge clk);
            #1 m_axis_tready[0] = 1'b0;
            @(negedge clk);
            check("stall_tready", 64'(s_axis_tready), 64'd0);
            check("stall_tvalid", 64'(m_axis_tvalid), 64'h01);
            check("stall_tdata", 64'(m_axis_tdata[DW-1:0]), 64'h301);
            repeat (5) @(posedge clk);
            #1 m_axis_tready[0] = 1'b1;
         end
      join
      drain();
      check_dest("t3_dst0", start, 0, 0);
      check("t3_npkts", 64'(dlog.size() - start), 64'd1);

      // No channel enabled: nothing moves until en_i[3] is set.
      reset_dut('0);
      start = dlog.size();
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'hDEAD;
      s_axis_tlast  = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("t4_idle_tready", 64'(s_axis_tready), 64'd0);
         check("t4_idle_sel", 64'(sel_o), 64'd0);
         check("t4_idle_tvalid", 64'(m_axis_tvalid), 64'd0);
      end
      @(posedge clk);
      #1 en_i = 8'h08;
      send_pkt(2, 32'h400);
      drain();
      check_dest("t4_dst0", start, 0, 3);

      // Reset during the third beat of a packet.
      reset_dut('1);
      start = dlog.size();
      send_pkt(2, 32'h500);
      send_beat(32'h600, 4'hF, 1'b0);
      send_beat(32'h601, 4'hF, 1'b0);
      check("t5_pre_tvalid", 64'(m_axis_tvalid), 64'h02);
      s_axis_tdata = 32'h602;
      arstn        = 1'b0;
      #1;
      check("t5_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      s_axis_tvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1 arstn = 1'b1;
      send_pkt(1, 32'h700);
      drain();
      check_dest("t5_dst0", start, 0, 0);
      check_dest("t5_dst1", start, 1, 0);
      check("t5_npkts", 64'(dlog.size() - start), 64'd2);

`ifdef AXIS_RR_DEMUX_PKT_CNT_EN
      // Counter wrap with only ch1 enabled.
      reset_dut(8'h02);
      for (int p = 0; p < 5; p++) send_pkt(1, 32'h800 + 32'(p));
      drain();
      for (int i = 0; i < int'(N); i++) begin
         check("cnt_literal", 64'(pkt_cnt_o[i*CW +: CW]), (i == 1) ? 64'd1 : 64'd0);
         check("cnt_model", 64'(pkt_cnt_o[i*CW +: CW]), 64'(mcnt[i]));
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
